// File: rtl/conv_window_fetch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : conv_window_fetch
//  Description : Walks a square feature map in raster order, reading the nine
//                pixels of each 3x3 window from the pixel RAM (one read per
//                cycle), and presents the packed window downstream through a
//                valid/ready handshake. One window in flight at a time.
//  Ports       : clk, rst            - clock, synchronous active-high reset
//                start               - begin one frame pass (sampled in IDLE)
//                busy, done          - pass in progress / end-of-pass pulse
//                re_p, read_addressp - pixel RAM read port
//                qp                  - pixel RAM data, one cycle after re_p
//                window_data         - tap k at [SIZE_1*(k+1)-1:SIZE_1*k]
//                window_valid/ready  - downstream handshake
//                win_row, win_col    - window coordinate
//  Options     : `define CONV_WINDOW_ZERO_PAD_EN selects 'same' padding
//                (centre-indexed windows, out-of-image taps read as zero).
//  Revision    : 1.0 - initial release
// ============================================================================
module conv_window_fetch #(
    parameter int picture_size     = 28,
    parameter int SIZE_1           = 16,
    parameter int SIZE_address_pix = 16,
    parameter int BASE_ADDR        = 0,
    parameter int COORD_W          = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    output logic                        busy,
    output logic                        done,
    output logic                        re_p,
    output logic [SIZE_address_pix-1:0] read_addressp,
    input  logic [SIZE_1-1:0]           qp,
    output logic [9*SIZE_1-1:0]         window_data,
    output logic                        window_valid,
    input  logic                        window_ready,
    output logic [COORD_W-1:0]          win_row,
    output logic [COORD_W-1:0]          win_col
);

    localparam int AW = SIZE_address_pix + COORD_W;

`ifdef CONV_WINDOW_ZERO_PAD_EN
    localparam logic [COORD_W-1:0] c_last_idx = COORD_W'(picture_size - 1);
`else
    localparam logic [COORD_W-1:0] c_last_idx = COORD_W'(picture_size - 3);
`endif

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_DRAIN = 3'd2,
        S_EMIT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [3:0]         r_k;
    logic [COORD_W-1:0] r_row;
    logic [COORD_W-1:0] r_col;
    logic [SIZE_1-1:0]  r_tap [9];
    logic               r_rd_prev;   // the read issued last cycle was a real RAM read

    logic [1:0]         w_dy;
    logic [1:0]         w_dx;
    logic [AW-1:0]      w_row_ext;
    logic [AW-1:0]      w_col_ext;
    logic [AW-1:0]      w_addr_full;
    logic               w_in_image;
    logic               w_last;

    // Tap offset inside the window for the current fetch slot
    always_comb begin
        w_dy = 2'd0;
        w_dx = 2'd0;
        case (r_k)
            4'd0: begin w_dy = 2'd0; w_dx = 2'd0; end
            4'd1: begin w_dy = 2'd0; w_dx = 2'd1; end
            4'd2: begin w_dy = 2'd0; w_dx = 2'd2; end
            4'd3: begin w_dy = 2'd1; w_dx = 2'd0; end
            4'd4: begin w_dy = 2'd1; w_dx = 2'd1; end
            4'd5: begin w_dy = 2'd1; w_dx = 2'd2; end
            4'd6: begin w_dy = 2'd2; w_dx = 2'd0; end
            4'd7: begin w_dy = 2'd2; w_dx = 2'd1; end
            4'd8: begin w_dy = 2'd2; w_dx = 2'd2; end
            default: begin w_dy = 2'd0; w_dx = 2'd0; end
        endcase
    end

    assign w_row_ext = AW'(r_row) + AW'(w_dy);
    assign w_col_ext = AW'(r_col) + AW'(w_dx);

`ifdef CONV_WINDOW_ZERO_PAD_EN
    // Centre-indexed: the image pixel is (row+dy-1, col+dx-1); ext==0 means -1.
    assign w_in_image  = (w_row_ext != '0) && (w_row_ext <= AW'(picture_size)) &&
                         (w_col_ext != '0) && (w_col_ext <= AW'(picture_size));
    assign w_addr_full = AW'(BASE_ADDR) + (w_row_ext - AW'(1)) * AW'(picture_size)
                       + (w_col_ext - AW'(1));
`else
    assign w_in_image  = 1'b1;
    assign w_addr_full = AW'(BASE_ADDR) + w_row_ext * AW'(picture_size) + w_col_ext;
`endif

    assign w_last = (r_row == c_last_idx) && (r_col == c_last_idx);

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_FETCH;
            S_FETCH: if (r_k == 4'd8) w_state_nxt = S_DRAIN;
            S_DRAIN: w_state_nxt = S_EMIT;
            S_EMIT:  if (window_ready) w_state_nxt = w_last ? S_DONE : S_FETCH;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        re_p          = 1'b0;
        read_addressp = '0;
        if (r_state == S_FETCH && w_in_image) begin
            re_p          = 1'b1;
            read_addressp = w_addr_full[SIZE_address_pix-1:0];
        end
    end

    assign busy         = (r_state == S_FETCH) || (r_state == S_DRAIN) || (r_state == S_EMIT);
    assign done         = (r_state == S_DONE);
    assign window_valid = (r_state == S_EMIT);
    assign win_row      = r_row;
    assign win_col      = r_col;

    generate
        for (genvar g = 0; g < 9; g++) begin : g_pack
            assign window_data[SIZE_1*g +: SIZE_1] = r_tap[g];
        end
    endgenerate

    // State, counters and tap capture
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_k       <= 4'd0;
            r_row     <= '0;
            r_col     <= '0;
            r_rd_prev <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                r_tap[i] <= '0;
            end
        end else begin
            r_state   <= w_state_nxt;
            r_rd_prev <= re_p;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_row <= '0;
                        r_col <= '0;
                        r_k   <= 4'd0;
                    end
                end
                S_FETCH: begin
                    r_k <= (r_k == 4'd8) ? 4'd0 : r_k + 4'd1;
                    // RAM data lags the address by one cycle, so slot k fills tap k-1
                    if (r_k != 4'd0) begin
                        r_tap[r_k - 4'd1] <= r_rd_prev ? qp : '0;
                    end
                end
                S_DRAIN: begin
                    r_tap[8] <= r_rd_prev ? qp : '0;
                end
                S_EMIT: begin
                    if (window_ready && !w_last) begin
                        if (r_col == c_last_idx) begin
                            r_col <= '0;
                            r_row <= r_row + 1'b1;
                        end else begin
                            r_col <= r_col + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_conv_window_fetch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_conv_window_fetch
//  Description : Self-checking bench for conv_window_fetch. A RAM model
//                returns pixel[a] = a; expected windows are queued when a pass
//                is started and compared as the DUT hands them over.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_window_fetch;

    localparam int P  = 28;
    localparam int W  = 16;
    localparam int AP = 16;
    localparam int CW = 8;
`ifdef CONV_WINDOW_ZERO_PAD_EN
    localparam int NW   = P * P;
    localparam int LAST = P - 1;
`else
    localparam int NW   = (P - 2) * (P - 2);
    localparam int LAST = P - 3;
`endif

    logic            clk = 1'b0;
    logic            rst, start, window_ready;
    logic            busy, done, re_p, window_valid;
    logic [AP-1:0]   read_addressp;
    logic [W-1:0]    qp;
    logic [9*W-1:0]  window_data;
    logic [CW-1:0]   win_row, win_col;

    logic            start_b, ready_b;
    logic            busy_b, done_b, re_p_b, valid_b;
    logic [AP-1:0]   addr_b;
    logic [W-1:0]    qp_b;
    logic [9*W-1:0]  data_b;
    logic [CW-1:0]   row_b, col_b;

    always #5 clk = ~clk;

    conv_window_fetch #(.picture_size(P), .SIZE_1(W), .SIZE_address_pix(AP),
                        .BASE_ADDR(0), .COORD_W(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .re_p(re_p), .read_addressp(read_addressp), .qp(qp),
        .window_data(window_data), .window_valid(window_valid),
        .window_ready(window_ready), .win_row(win_row), .win_col(win_col));

    conv_window_fetch #(.picture_size(P), .SIZE_1(W), .SIZE_address_pix(AP),
                        .BASE_ADDR(100), .COORD_W(CW)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
        .re_p(re_p_b), .read_addressp(addr_b), .qp(qp_b),
        .window_data(data_b), .window_valid(valid_b),
        .window_ready(ready_b), .win_row(row_b), .win_col(col_b));

    // RAM models: pixel at address a holds a
    always @(posedge clk) begin
        if (re_p)   qp   <= read_addressp;
        if (re_p_b) qp_b <= addr_b;
    end

    // ---------------- reference model ----------------
    function automatic bit tap_in(int r, int c, int k);
`ifdef CONV_WINDOW_ZERO_PAD_EN
        int rr, cc;
        rr = r + k / 3 - 1;
        cc = c + k % 3 - 1;
        return (rr >= 0) && (rr < P) && (cc >= 0) && (cc < P);
`else
        return 1'b1;
`endif
    endfunction

    function automatic int tap_addr(int base, int r, int c, int k);
`ifdef CONV_WINDOW_ZERO_PAD_EN
        return base + (r + k / 3 - 1) * P + (c + k % 3 - 1);
`else
        return base + (r + k / 3) * P + (c + k % 3);
`endif
    endfunction

    function automatic logic [9*W-1:0] exp_win(int base, int r, int c);
        logic [9*W-1:0] d;
        d = '0;
        for (int k = 0; k < 9; k++)
            if (tap_in(r, c, k)) d[W*k +: W] = W'(tap_addr(base, r, c, k));
        return d;
    endfunction

    typedef struct {
        int             row;
        int             col;
        logic [9*W-1:0] data;
    } exp_t;

    exp_t           sb[$];
    int             total = 0;
    int             bad = 0;
    int             hs_count = 0;
    logic [9*W-1:0] last_data;
    int             last_row, last_col;

    task automatic push_pass();
        exp_t e;
        sb.delete();
        for (int r = 0; r <= LAST; r++)
            for (int c = 0; c <= LAST; c++) begin
                e.row  = r;
                e.col  = c;
                e.data = exp_win(0, r, c);
                sb.push_back(e);
            end
    endtask

    // Scoreboard: every accepted window is compared against the queue head
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst && window_valid && window_ready) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL window_extra: got row=%0d col=%0d, queue empty", win_row, win_col);
            end else begin
                e = sb.pop_front();
                if (window_data !== e.data || win_row !== CW'(e.row) || win_col !== CW'(e.col)) begin
                    bad++;
                    $display("FAIL window: got r=%0d c=%0d data=%h, want r=%0d c=%0d data=%h",
                             win_row, win_col, window_data, e.row, e.col, e.data);
                end
            end
            hs_count++;
            last_data = window_data;
            last_row  = int'(win_row);
            last_col  = int'(win_col);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; window_ready = 1'b0; start_b = 1'b0; ready_b = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        total++;
        if ({busy, done, re_p, window_valid} !== 4'b0 || read_addressp !== '0 ||
            window_data !== '0 || win_row !== '0 || win_col !== '0) begin
            bad++;
            $display("FAIL reset_state: busy=%b done=%b re_p=%b valid=%b addr=%h data=%h row=%0d col=%0d, want all 0",
                     busy, done, re_p, window_valid, read_addressp, window_data, win_row, win_col);
        end
        tick();
        rst = 1'b0;
    endtask

    // Pass start with ready low: cycle-accurate read sequence and first window
    task automatic test_first_window();
        int rcnt, ercnt, ea;
        bit er;
        push_pass();
        hs_count = 0;
        window_ready = 1'b0;
        tick(); start = 1'b1;
        tick(); start = 1'b0;
        rcnt = 0; ercnt = 0;
        for (int i = 1; i <= 11; i++) begin
            @(negedge clk);
            if (i <= 9) begin
                er = tap_in(0, 0, i - 1);
                ea = er ? tap_addr(0, 0, 0, i - 1) : 0;
                if (er) ercnt++;
                if (re_p) rcnt++;
                total++;
                if (re_p !== er || read_addressp !== AP'(ea) || busy !== 1'b1 || window_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL fetch_cycle%0d: re_p=%b addr=%0d busy=%b valid=%b, want re_p=%b addr=%0d busy=1 valid=0",
                             i, re_p, read_addressp, busy, window_valid, er, ea);
                end
            end else if (i == 10) begin
                total++;
                if (re_p !== 1'b0 || read_addressp !== '0 || window_valid !== 1'b0 || busy !== 1'b1) begin
                    bad++;
                    $display("FAIL drain_cycle: re_p=%b addr=%0d valid=%b busy=%b, want 0 0 0 1",
                             re_p, read_addressp, window_valid, busy);
                end
            end else begin
                total++;
                if (window_valid !== 1'b1 || win_row !== '0 || win_col !== '0 || window_data !== exp_win(0, 0, 0)) begin
                    bad++;
                    $display("FAIL first_window: valid=%b row=%0d col=%0d data=%h, want 1 0 0 %h",
                             window_valid, win_row, win_col, window_data, exp_win(0, 0, 0));
                end
            end
        end
        total++;
        if (rcnt !== ercnt) begin
            bad++;
            $display("FAIL read_count: got %0d reads, want %0d", rcnt, ercnt);
        end
    endtask

    // Ready held low in EMIT: window must be frozen, then window 2 follows
    task automatic test_stall();
        logic [9*W-1:0] held;
        int ea;
        held = window_data;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            total++;
            if (window_valid !== 1'b1 || window_data !== held || win_col !== '0) begin
                bad++;
                $display("FAIL stall_hold%0d: valid=%b data=%h col=%0d, want 1 %h 0",
                         j, window_valid, window_data, win_col, held);
            end
        end
        tick();
        window_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        ea = tap_in(0, 1, 0) ? tap_addr(0, 0, 1, 0) : 0;
        total++;
        if (window_valid !== 1'b0 || re_p !== tap_in(0, 1, 0) || read_addressp !== AP'(ea)) begin
            bad++;
            $display("FAIL after_handshake: valid=%b re_p=%b addr=%0d, want valid=0 re_p=%b addr=%0d",
                     window_valid, re_p, read_addressp, tap_in(0, 1, 0), ea);
        end
    endtask

    // Run to the done pulse; optionally poke start while busy
    task automatic run_to_done(input bit poke);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 20000) begin
            @(negedge clk);
            n++;
            start = poke && (n % 500 == 0);
        end
        start = 1'b0;
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL done_timeout: no done after %0d cycles", n);
        end
        total++;
        if (busy !== 1'b0 || window_valid !== 1'b0) begin
            bad++;
            $display("FAIL done_state: busy=%b valid=%b, want 0 0", busy, window_valid);
        end
        @(negedge clk);
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL done_pulse: done=%b busy=%b one cycle later, want 0 0", done, busy);
        end
        total++;
        if (hs_count !== NW || sb.size() !== 0) begin
            bad++;
            $display("FAIL window_count: got %0d handshakes (%0d left), want %0d", hs_count, sb.size(), NW);
        end
    endtask

    task automatic test_full_pass();
        run_to_done(1'b0);
`ifndef CONV_WINDOW_ZERO_PAD_EN
        total++;
        if (last_row !== 25 || last_col !== 25 || last_data[15:0] !== 16'd725 ||
            last_data[4*W +: W] !== 16'd754 || last_data[8*W +: W] !== 16'd783) begin
            bad++;
            $display("FAIL last_window: r=%0d c=%0d data=%h, want (25,25) taps 725..783",
                     last_row, last_col, last_data);
        end
`endif
    endtask

    // Reset during FETCH of window 3, then restart with start pokes while busy
    task automatic test_reset_midpass();
        int n;
        push_pass();
        hs_count = 0;
        window_ready = 1'b1;
        tick(); start = 1'b1;
        tick(); start = 1'b0;
        n = 0;
        while (hs_count < 2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (hs_count < 2) begin
            bad++;
            $display("FAIL reset_setup: got %0d handshakes, want 2", hs_count);
        end
        tick(); tick();
        rst = 1'b1;
        tick();
        @(negedge clk);
        total++;
        if ({busy, done, re_p, window_valid} !== 4'b0 || read_addressp !== '0 ||
            window_data !== '0 || win_row !== '0 || win_col !== '0) begin
            bad++;
            $display("FAIL midpass_reset: busy=%b done=%b re_p=%b valid=%b addr=%h data=%h row=%0d col=%0d, want all 0",
                     busy, done, re_p, window_valid, read_addressp, window_data, win_row, win_col);
        end
        tick();
        rst = 1'b0;
        push_pass();
        hs_count = 0;
        tick(); start = 1'b1;
        tick(); start = 1'b0;
        run_to_done(1'b1);
    endtask

    // Second instance with a non-zero base address
    task automatic test_base();
        int ea;
        bit er;
        ready_b = 1'b1;
        tick(); start_b = 1'b1;
        tick(); start_b = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            er = tap_in(0, 0, i - 1);
            ea = er ? tap_addr(100, 0, 0, i - 1) : 0;
            total++;
            if (re_p_b !== er || addr_b !== AP'(ea)) begin
                bad++;
                $display("FAIL base_fetch%0d: re_p=%b addr=%0d, want %b %0d", i, re_p_b, addr_b, er, ea);
            end
        end
`ifndef CONV_WINDOW_ZERO_PAD_EN
        total++;
        if (addr_b !== 16'd158) begin
            bad++;
            $display("FAIL base_ninth_addr: got %0d, want 158", addr_b);
        end
`endif
        @(negedge clk);
        @(negedge clk);
        total++;
        if (valid_b !== 1'b1 || data_b !== exp_win(100, 0, 0) || row_b !== '0 || col_b !== '0) begin
            bad++;
            $display("FAIL base_window: valid=%b data=%h, want 1 %h", valid_b, data_b, exp_win(100, 0, 0));
        end
    endtask

    initial begin
        test_reset();
        test_first_window();
        test_stall();
        test_full_pass();
        test_reset_midpass();
        test_base();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
